fib_sequencer: RTL and testbench

Parametrised sequence-generation controller that drives the shared regfile/ALU datapath over its buses. It seeds two registers, then iterates r[k] = f(r[k-2], r[k-1]) one term per cycle, with a selectable add or subtract mode. It supports a programmable term count and ring-buffer wrap across the regfile. It also provides carry-based overflow stop and a start/busy/done handshake, so top-level and LCD logic can sample results.

---
 rtl/fib_sequencer_pkg.sv | 23 ++
 rtl/fib_sequencer_addr_gen.sv | 41 ++++
 rtl/fib_sequencer.sv | 156 +++++++++++++++
 tb/tb_fib_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_sequencer_pkg.sv
// Shared definitions for the sequence generator: ALU op codes, buffer
// control bit positions and the controller state encoding.
package fib_sequencer_pkg;

    localparam logic [7:0] ALU_OP_NOP = 8'h00;
    localparam logic [7:0] ALU_OP_ADD = 8'h05;
    localparam logic [7:0] ALU_OP_SUB = 8'h09;

    // Bit positions inside buf_ctrl.
    localparam int BUF_INIT = 0;
    localparam int BUF_A    = 1;
    localparam int BUF_B    = 2;
    localparam int BUF_ALU  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED0   = 3'd1,
        ST_SEED1   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/fib_sequencer_addr_gen.sv
// Term counter and ring-buffer address generation. The counter is loaded
// with 2 (first computed term) when a run is accepted and advances once per
// compute cycle; the regfile addresses are its low bits, so they wrap
// naturally at NUM_REGS.
module seq_addr_gen
    import fib_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               step,
    input  logic [COUNT_W-1:0] term_count,
    output logic [ADDR_W-1:0]  rd_a,
    output logic [ADDR_W-1:0]  rd_b,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic               is_last
);

    logic [COUNT_W-1:0] k;

    // Term index: load on accepted start, advance per written compute term.
    always_ff @(posedge clk) begin
        if (reset) begin
            k <= '0;
        end else if (init) begin
            k <= COUNT_W'(2);
        end else if (step) begin
            k <= k + COUNT_W'(1);
        end
    end

    assign wr_addr = ADDR_W'(k);
    assign rd_b    = ADDR_W'(k - COUNT_W'(1));
    assign rd_a    = ADDR_W'(k - COUNT_W'(2));
    // Only consulted in compute cycles, where term_count is at least 3.
    assign is_last = (k == (term_count - COUNT_W'(1)));

endmodule

// File: rtl/fib_sequencer.sv
// Sequence-generation controller: seeds two regfile entries, then drives the
// ALU datapath to produce r[k] = r[k-2] +/- r[k-1] one term per cycle.
// Handshake: start is a one-cycle request honoured only in idle; busy is high
// while terms are being written; done pulses for one cycle when a run ends.
module fib_sequencer
    import fib_sequencer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   seed0,
    input  logic [WIDTH-1:0]   seed1,
    input  logic [COUNT_W-1:0] term_count,
    input  logic               alu_carry,
    output logic [WIDTH-1:0]   init_value,
    output logic [ADDR_W-1:0]  reg_write,
    output logic [ADDR_W-1:0]  reg_read1,
    output logic [ADDR_W-1:0]  reg_read2,
    output logic               reg_write_en,
    output logic [7:0]         alu_op,
    output logic [3:0]         buf_ctrl,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [ADDR_W-1:0]  last_addr
);

    state_t             state;
    state_t             state_next;
    logic               cfg_mode;
    logic [WIDTH-1:0]   cfg_seed0;
    logic [WIDTH-1:0]   cfg_seed1;
    logic [COUNT_W-1:0] cfg_count;
    logic               accept;
    logic               carry_stop;
    logic [ADDR_W-1:0]  ag_rd_a;
    logic [ADDR_W-1:0]  ag_rd_b;
    logic [ADDR_W-1:0]  ag_wr;
    logic               ag_last;

    assign accept     = (state == ST_IDLE) && start;
    assign carry_stop = (state == ST_COMPUTE) && !cfg_mode && alu_carry;

    seq_addr_gen #(
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .init       (accept),
        .step       (state == ST_COMPUTE),
        .term_count (cfg_count),
        .rd_a       (ag_rd_a),
        .rd_b       (ag_rd_b),
        .wr_addr    (ag_wr),
        .is_last    (ag_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Latch the run configuration so it stays stable until the run ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_mode  <= 1'b0;
            cfg_seed0 <= '0;
            cfg_seed1 <= '0;
            cfg_count <= '0;
        end else if (accept) begin
            cfg_mode  <= mode;
            cfg_seed0 <= seed0;
            cfg_seed1 <= seed1;
            cfg_count <= term_count;
        end
    end

    // Sticky overflow flag and address of the most recent written term.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            last_addr <= '0;
        end else if (accept) begin
            overflow  <= 1'b0;
            last_addr <= '0;
        end else begin
            case (state)
                ST_SEED0:   last_addr <= '0;
                ST_SEED1:   last_addr <= ADDR_W'(1);
                ST_COMPUTE: last_addr <= ag_wr;
                default:    last_addr <= last_addr;
            endcase
            if (carry_stop) overflow <= 1'b1;
        end
    end

    // Next-state and bus-control decode.
    always_comb begin
        state_next   = state;
        init_value   = '0;
        reg_write    = '0;
        reg_read1    = '0;
        reg_read2    = '0;
        reg_write_en = 1'b0;
        alu_op       = ALU_OP_NOP;
        buf_ctrl     = 4'b0000;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_SEED0;
            end
            ST_SEED0: begin
                busy               = 1'b1;
                init_value         = cfg_seed0;
                buf_ctrl[BUF_INIT] = 1'b1;
                reg_write_en       = 1'b1;
                state_next         = ST_SEED1;
            end
            ST_SEED1: begin
                busy               = 1'b1;
                init_value         = cfg_seed1;
                buf_ctrl[BUF_INIT] = 1'b1;
                reg_write          = ADDR_W'(1);
                reg_write_en       = 1'b1;
                state_next = (cfg_count <= COUNT_W'(2)) ? ST_DONE : ST_COMPUTE;
            end
            ST_COMPUTE: begin
                busy              = 1'b1;
                reg_read1         = ag_rd_a;
                reg_read2         = ag_rd_b;
                reg_write         = ag_wr;
                reg_write_en      = 1'b1;
                buf_ctrl[BUF_A]   = 1'b1;
                buf_ctrl[BUF_B]   = 1'b1;
                buf_ctrl[BUF_ALU] = 1'b1;
                alu_op            = cfg_mode ? ALU_OP_SUB : ALU_OP_ADD;
                // A carried term is still written, but ends the run.
                if (carry_stop || ag_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer with a behavioural regfile/ALU datapath.
module tb_fib_sequencer;

    localparam int WIDTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int COUNT_W = 8;
    localparam int NREGS   = 16;

    logic               clk;
    logic               reset;
    logic               start;
    logic               mode;
    logic [WIDTH-1:0]   seed0;
    logic [WIDTH-1:0]   seed1;
    logic [COUNT_W-1:0] term_count;
    logic               alu_carry;
    logic [WIDTH-1:0]   init_value;
    logic [ADDR_W-1:0]  reg_write;
    logic [ADDR_W-1:0]  reg_read1;
    logic [ADDR_W-1:0]  reg_read2;
    logic               reg_write_en;
    logic [7:0]         alu_op;
    logic [3:0]         buf_ctrl;
    logic               busy;
    logic               done;
    logic               overflow;
    logic [ADDR_W-1:0]  last_addr;

    fib_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .seed0        (seed0),
        .seed1        (seed1),
        .term_count   (term_count),
        .alu_carry    (alu_carry),
        .init_value   (init_value),
        .reg_write    (reg_write),
        .reg_read1    (reg_read1),
        .reg_read2    (reg_read2),
        .reg_write_en (reg_write_en),
        .alu_op       (alu_op),
        .buf_ctrl     (buf_ctrl),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .last_addr    (last_addr)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: regfile plus ALU with carry (add) / borrow (sub).
    logic [WIDTH-1:0] mem [NREGS];
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic             clr_mem;

    always_comb begin
        sum       = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        if (alu_op == 8'h05) begin
            sum       = {1'b0, mem[reg_read1]} + {1'b0, mem[reg_read2]};
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
        end else if (alu_op == 8'h09) begin
            alu_res   = mem[reg_read1] - mem[reg_read2];
            alu_carry = (mem[reg_read1] < mem[reg_read2]);
        end
    end

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= 16'hDEAD;
        end else if (reg_write_en) begin
            mem[reg_write] <= buf_ctrl[0] ? init_value : alu_res;
        end
    end

    // Scoreboard.
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare regfile entries base.. against the expected queue, in order.
    task automatic check_mem(input string tag, input int base);
        int a;
        a = base;
        while (exp_q.size() > 0) begin
            check_eq($sformatf("%s_mem%0d", tag, a), 32'(mem[a]), 32'(exp_q.pop_front()));
            a++;
        end
    endtask

    task automatic clear_mem();
        @(negedge clk);
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
    endtask

    // Run observations.
    int         done_cyc;
    int         busy_cyc;
    int         comp_cyc;
    int         contention;
    logic [7:0] op_seen;
    logic [3:0] wrap_rd1;
    logic [3:0] wrap_rd2;
    logic       last_carry;

    // Drive one run; glitch > 0 pulses start (with altered inputs) in that cycle.
    task automatic run_seq(input logic m, input logic [15:0] s0, input logic [15:0] s1,
                           input logic [7:0] n, input int glitch);
        done_cyc = -1; busy_cyc = 0; comp_cyc = 0; contention = 0;
        op_seen = 8'h00; wrap_rd1 = 4'hF; wrap_rd2 = 4'hF; last_carry = 1'b0;
        @(negedge clk);
        mode = m; seed0 = s0; seed1 = s1; term_count = n; start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == glitch) begin
                start = 1'b1; mode = ~m; seed0 = 16'h5555; seed1 = 16'h7777; term_count = 8'd3;
            end
            if (busy) busy_cyc++;
            if (buf_ctrl[0] && buf_ctrl[3]) contention++;
            if (buf_ctrl == 4'b1110) begin
                comp_cyc++;
                op_seen    = alu_op;
                last_carry = alu_carry;
                if (reg_write == 4'd0) begin
                    wrap_rd1 = reg_read1;
                    wrap_rd2 = reg_read2;
                end
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check_eq("done_one_cycle", {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; seed0 = '0; seed1 = '0;
        term_count = '0; clr_mem = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {init_value, reg_write, reg_read1, reg_read2, reg_write_en,
                                 alu_op, buf_ctrl, busy, done, overflow, last_addr}, 0);
        reset = 1'b0;

        // Fibonacci N=10, with a start pulse mid-compute that must be ignored.
        clear_mem();
        run_seq(1'b0, 16'd0, 16'd1, 8'd10, 5);
        check_eq("fib_done_cyc", 32'(done_cyc), 32'd11);
        check_eq("fib_busy_cyc", 32'(busy_cyc), 32'd10);
        check_eq("fib_comp_cyc", 32'(comp_cyc), 32'd8);
        check_eq("fib_last_addr", 32'(last_addr), 32'd9);
        check_eq("fib_overflow", 32'(overflow), 32'd0);
        check_eq("fib_op", 32'(op_seen), 32'h05);
        check_eq("fib_contention", 32'(contention), 32'd0);
        exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 16'hDEAD};
        check_mem("fib", 0);

        // Wrap-around N=20.
        clear_mem();
        run_seq(1'b0, 16'd0, 16'd1, 8'd20, 0);
        check_eq("wrap_done_cyc", 32'(done_cyc), 32'd21);
        check_eq("wrap_last_addr", 32'(last_addr), 32'd3);
        check_eq("wrap_rd1", 32'(wrap_rd1), 32'd14);
        check_eq("wrap_rd2", 32'(wrap_rd2), 32'd15);
        exp_q = '{987, 1597, 2584, 4181, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
        check_mem("wrap", 0);

        // Carry stop on F(25).
        clear_mem();
        run_seq(1'b0, 16'd0, 16'd1, 8'd30, 0);
        check_eq("ovf_done_cyc", 32'(done_cyc), 32'd27);
        check_eq("ovf_last_addr", 32'(last_addr), 32'd9);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_carry", 32'(last_carry), 32'd1);
        exp_q = '{16'h2511, 55};
        check_mem("ovf", 9);

        // Reset in idle clears the sticky overflow.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_eq("rst_clears_ovf", 32'(overflow), 32'd0);

        // Subtract mode; borrows from the ALU must not stop the run.
        clear_mem();
        run_seq(1'b1, 16'd10, 16'd3, 8'd5, 0);
        check_eq("sub_done_cyc", 32'(done_cyc), 32'd6);
        check_eq("sub_op", 32'(op_seen), 32'h09);
        check_eq("sub_overflow", 32'(overflow), 32'd0);
        check_eq("sub_last_addr", 32'(last_addr), 32'd4);
        exp_q = '{10, 3, 7, 16'hFFFC, 16'h000B, 16'hDEAD};
        check_mem("sub", 0);

        // Short counts: only the seeds are written.
        for (int n = 0; n < 2; n++) begin
            clear_mem();
            run_seq(1'b0, 16'h0A0A, 16'h0B0B, 8'(n), 0);
            check_eq($sformatf("n%0d_done_cyc", n), 32'(done_cyc), 32'd3);
            check_eq($sformatf("n%0d_comp_cyc", n), 32'(comp_cyc), 32'd0);
            check_eq($sformatf("n%0d_last_addr", n), 32'(last_addr), 32'd1);
            exp_q = '{16'h0A0A, 16'h0B0B, 16'hDEAD};
            check_mem($sformatf("n%0d", n), 0);
        end

        // Reset mid-compute aborts; a fresh run then works.
        clear_mem();
        @(negedge clk);
        mode = 1'b0; seed0 = 16'd0; seed1 = 16'd1; term_count = 8'd10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("abort_in_compute", 32'(buf_ctrl), 32'hE);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_outputs", {init_value, reg_write, reg_read1, reg_read2, reg_write_en,
                                   alu_op, buf_ctrl, busy, done, overflow, last_addr}, 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_quiet", {30'd0, reg_write_en, busy}, 32'd0);
        end
        clear_mem();
        run_seq(1'b0, 16'd2, 16'd3, 8'd4, 0);
        check_eq("fresh_done_cyc", 32'(done_cyc), 32'd5);
        check_eq("fresh_last_addr", 32'(last_addr), 32'd3);
        exp_q = '{2, 3, 5, 8, 16'hDEAD};
        check_mem("fresh", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
